mem_stage_lsu: RTL and testbench

Memory-stage load/store unit. It is the writer side of the MEM/WB pipeline register: it drives that register's write-side inputs (ALU output, load data, destination, RegWrite, MemToReg) and its enable. It sits between the EX/MEM register and a req/ack data-memory port, formats loads and stores by funct3, and stalls the pipeline until the memory access completes.

---
 rtl/core_pkg.sv | 50 +++++
 rtl/load_formatter.sv | 35 +++
 rtl/mem_stage_lsu.sv | 186 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the memory-stage load/store unit.
package core_pkg;

  localparam int ACCESS_W = 32;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // size is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == 2'b01 && addr_lo[0]) mis = 1'b1;
    if (size == 2'b10 && addr_lo != 2'b00) mis = 1'b1;
    return mis;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Sub-word stores are replicated across lanes; byte enables pick the lane.
  function automatic logic [ACCESS_W-1:0] store_wdata(input logic [1:0] size,
                                                      input logic [ACCESS_W-1:0] data);
    logic [ACCESS_W-1:0] wd;
    case (size)
      2'b00:   wd = {4{data[7:0]}};
      2'b01:   wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Extracts and extends the addressed byte/halfword from a read word.
module load_formatter
  import core_pkg::*;
(
  input  logic [ACCESS_W-1:0] rdata,
  input  logic [1:0]          addr,
  input  logic [2:0]          funct3,
  output logic [ACCESS_W-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select, then sign/zero extension by funct3; unknown codes read as words.
  always_comb begin
    byte_v = 8'h00;
    half_v = 16'h0000;
    data   = rdata;
    case (addr)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_BU:   data = {24'h000000, byte_v};
      F3_HU:   data = {16'h0000, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives the MEM/WB write side and a req/ack
// data-memory port, stalling the pipeline while an access is outstanding.
//
// state | meaning
// IDLE  | no access in flight; non-memory ops pass straight through
// BUSY  | request on the bus, waiting for ack or timeout
// RESP  | one cycle: result presented to MEM/WB, stall released
module mem_stage_lsu
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exValid,
  input  logic [ACCESS_W-1:0] exALUOutput,
  input  logic [ACCESS_W-1:0] exStoreData,
  input  logic [4:0]          exWriteDir,
  input  logic                exRegWrite,
  input  logic                exMemToReg,
  input  logic                exMemRead,
  input  logic                exMemWrite,
  input  logic [2:0]          exFunct3,
  output logic [ACCESS_W-1:0] writeALUOutput,
  output logic [ACCESS_W-1:0] writeDataOutput,
  output logic [4:0]          writeWriteDir,
  output logic                writeRegWrite,
  output logic                writeMemToReg,
  output logic                memwbEn,
  output logic                stall,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ACCESS_W-1:0] dmem_addr,
  output logic [ACCESS_W-1:0] dmem_wdata,
  output logic [3:0]          dmem_be,
  input  logic                dmem_ack,
  input  logic [ACCESS_W-1:0] dmem_rdata,
  output logic                misalignFault,
  output logic                busErrFault
);

  // Timeout fires in the last allowed BUSY cycle, giving exactly TIMEOUT_CYCLES of BUSY.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ACCESS_W-1:0] addr_q, addr_d;
  logic [ACCESS_W-1:0] wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [ACCESS_W-1:0] data_q, data_d;
  logic                berr_flag_q, berr_flag_d;
  logic                mis_pulse_q, mis_pulse_d;
  logic                berr_pulse_q, berr_pulse_d;

  logic                memop;
  logic                misaligned;
  logic [ACCESS_W-1:0] load_data;
  logic                stall_c;
  logic                regwrite_c;
  logic [ACCESS_W-1:0] wdata_out_c;

  assign memop      = exValid & (exMemRead | exMemWrite);
  assign misaligned = is_misaligned(exFunct3[1:0], exALUOutput[1:0]);

  load_formatter u_load_formatter (
    .rdata  (dmem_rdata),
    .addr   (exALUOutput[1:0]),
    .funct3 (exFunct3),
    .data   (load_data)
  );

  // State and bus registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= 4'b0000;
      data_q       <= '0;
      berr_flag_q  <= 1'b0;
      mis_pulse_q  <= 1'b0;
      berr_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      data_q       <= data_d;
      berr_flag_q  <= berr_flag_d;
      mis_pulse_q  <= mis_pulse_d;
      berr_pulse_q <= berr_pulse_d;
    end
  end

  // Next-state, bus launch/completion and write-side qualification.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    data_d       = data_q;
    berr_flag_d  = berr_flag_q;
    mis_pulse_d  = 1'b0;
    berr_pulse_d = 1'b0;
    stall_c      = 1'b0;
    regwrite_c   = exRegWrite;
    wdata_out_c  = '0;

    case (state_q)
      IDLE: begin
        if (memop) begin
          if (misaligned) begin
            mis_pulse_d = 1'b1;
            regwrite_c  = 1'b0;
          end else begin
            stall_c     = 1'b1;
            state_d     = BUSY;
            cnt_d       = '0;
            req_d       = 1'b1;
            we_d        = exMemWrite;
            addr_d      = {exALUOutput[ACCESS_W-1:2], 2'b00};
            be_d        = store_be(exFunct3[1:0], exALUOutput[1:0]);
            wdata_d     = store_wdata(exFunct3[1:0], exStoreData);
            berr_flag_d = 1'b0;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        // ack has priority over a timeout in the same cycle
        if (dmem_ack) begin
          data_d  = load_data;
          req_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d       = '0;
          req_d        = 1'b0;
          berr_flag_d  = 1'b1;
          berr_pulse_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        wdata_out_c = data_q;
        regwrite_c  = exRegWrite & ~exMemWrite & ~berr_flag_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      stall_c    = 1'b0;
      regwrite_c = 1'b0;
    end
  end

  assign writeALUOutput  = exALUOutput;
  assign writeWriteDir   = exWriteDir;
  assign writeMemToReg   = exMemToReg;
  assign writeDataOutput = wdata_out_c;
  assign writeRegWrite   = regwrite_c;
  assign stall           = stall_c;
  assign memwbEn         = ~stall_c;

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign dmem_be       = be_q;
  assign misalignFault = mis_pulse_q;
  assign busErrFault   = berr_pulse_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: vector table of accesses with a result scoreboard,
// plus reset, pass-through and abort sequences.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        exValid;
  logic [31:0] exALUOutput;
  logic [31:0] exStoreData;
  logic [4:0]  exWriteDir;
  logic        exRegWrite;
  logic        exMemToReg;
  logic        exMemRead;
  logic        exMemWrite;
  logic [2:0]  exFunct3;
  logic [31:0] writeALUOutput;
  logic [31:0] writeDataOutput;
  logic [4:0]  writeWriteDir;
  logic        writeRegWrite;
  logic        writeMemToReg;
  logic        memwbEn;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        misalignFault;
  logic        busErrFault;

  mem_stage_lsu #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .exValid(exValid), .exALUOutput(exALUOutput),
    .exStoreData(exStoreData), .exWriteDir(exWriteDir), .exRegWrite(exRegWrite),
    .exMemToReg(exMemToReg), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
    .exFunct3(exFunct3), .writeALUOutput(writeALUOutput),
    .writeDataOutput(writeDataOutput), .writeWriteDir(writeWriteDir),
    .writeRegWrite(writeRegWrite), .writeMemToReg(writeMemToReg),
    .memwbEn(memwbEn), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .misalignFault(misalignFault), .busErrFault(busErrFault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        st;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ack_dly;   // BUSY cycle in which ack arrives; 0 = never
    logic [31:0] exp_data;
    logic        exp_rw;
    int          exp_stall;
    logic        exp_mis;
    logic        exp_berr;
    logic [31:0] exp_daddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        rw;
    int          stall_cyc;
    logic        mis;
    logic        berr;
  } exp_t;

  vec_t vecs[13];
  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] f3, input logic st, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rdata, input int ack_dly,
                              input logic [31:0] exp_data, input logic exp_rw, input int exp_stall,
                              input logic exp_mis, input logic exp_berr, input logic [31:0] exp_daddr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    vec_t v;
    v.f3 = f3; v.st = st; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.ack_dly = ack_dly; v.exp_data = exp_data; v.exp_rw = exp_rw;
    v.exp_stall = exp_stall; v.exp_mis = exp_mis; v.exp_berr = exp_berr;
    v.exp_daddr = exp_daddr; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic do_access(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    int   stall_cnt;
    bit   done;
    bit   saw_req;
    @(posedge clk); #1;
    exValid     = 1'b1;
    exALUOutput = v.addr;
    exStoreData = v.sdata;
    exWriteDir  = 5'd3;
    exRegWrite  = 1'b1;   // also set for stores: the unit must suppress it
    exMemToReg  = ~v.st;
    exMemRead   = ~v.st;
    exMemWrite  = v.st;
    exFunct3    = v.f3;
    dmem_ack    = 1'b0;
    dmem_rdata  = 32'h0;
    e.data = v.exp_data; e.rw = v.exp_rw; e.stall_cyc = v.exp_stall;
    e.mis = v.exp_mis; e.berr = v.exp_berr;
    sb_q.push_back(e);
    stall_cnt = 0;
    done      = 0;
    saw_req   = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall) begin
        stall_cnt++;
        if (dmem_req) begin
          if (!saw_req) begin
            chk($sformatf("v%0d dmem_addr", idx), dmem_addr, v.exp_daddr);
            chk($sformatf("v%0d dmem_we", idx), {31'b0, dmem_we}, {31'b0, v.st});
            if (v.st) begin
              chk($sformatf("v%0d dmem_be", idx), {28'b0, dmem_be}, {28'b0, v.exp_be});
              chk($sformatf("v%0d dmem_wdata", idx), dmem_wdata, v.exp_wdata);
            end
          end
          saw_req = 1;
          if (v.ack_dly != 0 && stall_cnt == v.ack_dly + 1) begin
            dmem_ack   = 1'b1;
            dmem_rdata = v.rdata;
          end
        end
        @(posedge clk); #1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL v%0d completion actual=timeout expected=resp", idx);
      void'(sb_q.pop_front());
    end else begin
      got = sb_q.pop_front();
      chk($sformatf("v%0d writeDataOutput", idx), writeDataOutput, got.data);
      chk($sformatf("v%0d writeRegWrite", idx), {31'b0, writeRegWrite}, {31'b0, got.rw});
      chk($sformatf("v%0d memwbEn", idx), {31'b0, memwbEn}, 32'd1);
      chk($sformatf("v%0d stall_cycles", idx), stall_cnt, got.stall_cyc);
      chk($sformatf("v%0d busErrFault", idx), {31'b0, busErrFault}, {31'b0, got.berr});
      chk($sformatf("v%0d dmem_req_done", idx), {31'b0, dmem_req}, 32'd0);
      chk($sformatf("v%0d req_seen", idx), {31'b0, saw_req}, {31'b0, ~got.mis});
      chk($sformatf("v%0d writeWriteDir", idx), {27'b0, writeWriteDir}, 32'd3);
      @(posedge clk); #1;
      exValid    = 1'b0;
      exMemRead  = 1'b0;
      exMemWrite = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d misalignFault", idx), {31'b0, misalignFault}, {31'b0, got.mis});
    end
  endtask

  initial begin
    rst = 1'b1; exValid = 0; exALUOutput = 0; exStoreData = 0; exWriteDir = 0;
    exRegWrite = 1; exMemToReg = 0; exMemRead = 0; exMemWrite = 0; exFunct3 = 0;
    dmem_ack = 0; dmem_rdata = 0;

    //            f3      st    addr          sdata         rdata         ack  exp_data      rw  stl mis berr daddr         be       wdata
    vecs[0]  = mk(3'b010, 1'b0, 32'h00000100, 32'h0,        32'hDEADBEEF, 3,  32'hDEADBEEF, 1, 4,  0, 0, 32'h00000100, 4'b1111, 32'h0);
    vecs[1]  = mk(3'b000, 1'b0, 32'h00000103, 32'h0,        32'h80FFFFFF, 1,  32'hFFFFFF80, 1, 2,  0, 0, 32'h00000100, 4'b0000, 32'h0);
    vecs[2]  = mk(3'b100, 1'b0, 32'h00000103, 32'h0,        32'h80FFFFFF, 2,  32'h00000080, 1, 3,  0, 0, 32'h00000100, 4'b0000, 32'h0);
    vecs[3]  = mk(3'b101, 1'b0, 32'h00000102, 32'h0,        32'hBEEF0000, 2,  32'h0000BEEF, 1, 3,  0, 0, 32'h00000100, 4'b0000, 32'h0);
    vecs[4]  = mk(3'b001, 1'b0, 32'h00000102, 32'h0,        32'h80010000, 1,  32'hFFFF8001, 1, 2,  0, 0, 32'h00000100, 4'b0000, 32'h0);
    vecs[5]  = mk(3'b000, 1'b0, 32'h00000100, 32'h0,        32'h1234567F, 1,  32'h0000007F, 1, 2,  0, 0, 32'h00000100, 4'b0000, 32'h0);
    vecs[6]  = mk(3'b000, 1'b1, 32'h00000201, 32'h000000AB, 32'h0,        2,  32'h0,        0, 3,  0, 0, 32'h00000200, 4'b0010, 32'hABABABAB);
    vecs[7]  = mk(3'b001, 1'b1, 32'h00000206, 32'h1234CAFE, 32'h0,        1,  32'h0,        0, 2,  0, 0, 32'h00000204, 4'b1100, 32'hCAFECAFE);
    vecs[8]  = mk(3'b010, 1'b1, 32'h00000208, 32'h12345678, 32'h0,        1,  32'h0,        0, 2,  0, 0, 32'h00000208, 4'b1111, 32'h12345678);
    vecs[9]  = mk(3'b010, 1'b0, 32'h00000102, 32'h0,        32'h0,        0,  32'h0,        0, 0,  1, 0, 32'h0,        4'b0000, 32'h0);
    vecs[10] = mk(3'b001, 1'b0, 32'h00000101, 32'h0,        32'h0,        0,  32'h0,        0, 0,  1, 0, 32'h0,        4'b0000, 32'h0);
    vecs[11] = mk(3'b010, 1'b0, 32'h00000300, 32'h0,        32'h0,        0,  32'h0,        0, 17, 0, 1, 32'h00000300, 4'b0000, 32'h0);
    vecs[12] = mk(3'b011, 1'b0, 32'h0000010C, 32'h0,        32'h11223344, 1,  32'h11223344, 1, 2,  0, 0, 32'h0000010C, 4'b0000, 32'h0);

    // reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst stall", {31'b0, stall}, 32'd0);
    chk("rst writeRegWrite", {31'b0, writeRegWrite}, 32'd0);
    chk("rst faults", {30'b0, misalignFault, busErrFault}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // non-memory op passes straight through
    exValid = 1; exALUOutput = 32'h00000055; exWriteDir = 5'd7; exRegWrite = 1;
    exMemToReg = 0; exMemRead = 0; exMemWrite = 0;
    @(negedge clk);
    chk("pass writeALUOutput", writeALUOutput, 32'h00000055);
    chk("pass writeRegWrite", {31'b0, writeRegWrite}, 32'd1);
    chk("pass writeWriteDir", {27'b0, writeWriteDir}, 32'd7);
    chk("pass stall", {31'b0, stall}, 32'd0);
    chk("pass memwbEn", {31'b0, memwbEn}, 32'd1);
    chk("pass writeDataOutput", writeDataOutput, 32'd0);
    @(posedge clk); #1 exValid = 0;

    for (int i = 0; i < 13; i++) do_access(vecs[i], i);

    // reset during the second BUSY cycle, followed by a late ack
    @(posedge clk); #1;
    exValid = 1; exALUOutput = 32'h00000400; exFunct3 = 3'b010; exRegWrite = 1;
    exMemToReg = 1; exMemRead = 1; exMemWrite = 0;
    @(posedge clk); #1;   // first BUSY cycle
    @(negedge clk);
    chk("abort busy req", {31'b0, dmem_req}, 32'd1);
    @(posedge clk); #1;   // second BUSY cycle
    rst = 1'b1;
    @(negedge clk);
    chk("abort rst stall", {31'b0, stall}, 32'd0);
    chk("abort rst writeRegWrite", {31'b0, writeRegWrite}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; exValid = 0; exMemRead = 0;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("abort dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("abort stall", {31'b0, stall}, 32'd0);
    chk("abort late ack data", writeDataOutput, 32'd0);
    @(posedge clk); #1 dmem_ack = 1'b0; dmem_rdata = 32'h0;
    @(negedge clk);
    chk("abort after ack data", writeDataOutput, 32'd0);
    chk("abort after ack req", {31'b0, dmem_req}, 32'd0);
    chk("abort after ack busErr", {31'b0, busErrFault}, 32'd0);

    chk("scoreboard empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
